// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared pipeline types and forwarding select codes
package fwd_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } stage_t;

  function automatic logic is_live(stage_t s);
    return s.v && (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - ID-stage request and EX-stage forwarding/stall bundle
interface fwd_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic                                   id_valid;
  logic [fwd_hazard_ctrl_pkg::REG_AW-1:0] id_rs;
  logic [fwd_hazard_ctrl_pkg::REG_AW-1:0] id_rt;
  logic                                   id_uses_rs;
  logic                                   id_uses_rt;
  logic                                   id_reg_write;
  logic [fwd_hazard_ctrl_pkg::REG_AW-1:0] id_wr_reg;
  logic                                   id_mem_to_reg;
  logic                                   flush;
  logic                                   stall;
  logic [1:0]                             fwd_a_sel;
  logic [1:0]                             fwd_b_sel;
  logic                                   ex_valid;
  logic [CNT_W-1:0]                       stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_wr_reg, id_mem_to_reg, flush,
    input  stall, fwd_a_sel, fwd_b_sel, ex_valid, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_wr_reg, id_mem_to_reg, flush,
    output stall, fwd_a_sel, fwd_b_sel, ex_valid, stall_count
  );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// rtl/fwd_hazard_ctrl_fwd_match.sv - operand select for one ALU source, youngest producer first
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  stage_t            i_e,
  input  logic              i_m_v,
  input  logic [REG_AW-1:0] i_m_rd,
  output logic [1:0]        o_sel
);

  logic w_e_hit;
  logic w_m_hit;

  // A load in E has no ALU result yet; that case is covered by the stall.
  assign w_e_hit = i_use && is_live(i_e) && !i_e.ld && (i_e.rd == i_src);
  assign w_m_hit = i_use && i_m_v && (i_m_rd != '0) && (i_m_rd == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_e_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_m_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects, load-use stall and stall counter
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  fwd_hazard_ctrl_if.slave  bus
);

  stage_t            r_e;
  logic              r_m_v;
  logic [REG_AW-1:0] r_m_rd;
  logic [1:0]        r_a_sel;
  logic [1:0]        r_b_sel;
  logic              r_ex_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic       w_hz;
  logic       w_stall;
  logic       w_bubble;
  logic [1:0] w_a_sel;
  logic [1:0] w_b_sel;

  assign w_hz = bus.id_valid && is_live(r_e) && r_e.ld &&
                ((bus.id_uses_rs && (bus.id_rs == r_e.rd)) ||
                 (bus.id_uses_rt && (bus.id_rt == r_e.rd)));

  // A flushed instruction never needs its operands, so flush masks the stall.
  assign w_stall  = rst_n && w_hz && !bus.flush;
  assign w_bubble = !bus.id_valid || w_stall || bus.flush;

  fwd_match u_fwd_a (
    .i_src  (bus.id_rs),
    .i_use  (bus.id_uses_rs),
    .i_e    (r_e),
    .i_m_v  (r_m_v),
    .i_m_rd (r_m_rd),
    .o_sel  (w_a_sel)
  );

  fwd_match u_fwd_b (
    .i_src  (bus.id_rt),
    .i_use  (bus.id_uses_rt),
    .i_e    (r_e),
    .i_m_v  (r_m_v),
    .i_m_rd (r_m_rd),
    .o_sel  (w_b_sel)
  );

  // W-stage producers reach EX through the register-file write-through,
  // so only E and M are tracked here; M no longer needs the load flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_e        <= '0;
      r_m_v      <= 1'b0;
      r_m_rd     <= '0;
      r_a_sel    <= FWD_RF;
      r_b_sel    <= FWD_RF;
      r_ex_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_m_v  <= r_e.v;
      r_m_rd <= r_e.rd;
      if (w_bubble) begin
        r_e        <= '0;
        r_a_sel    <= FWD_RF;
        r_b_sel    <= FWD_RF;
        r_ex_valid <= 1'b0;
      end else begin
        r_e.v      <= bus.id_reg_write;
        r_e.rd     <= bus.id_wr_reg;
        r_e.ld     <= bus.id_mem_to_reg;
        r_a_sel    <= w_a_sel;
        r_b_sel    <= w_b_sel;
        r_ex_valid <= 1'b1;
      end
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall       = w_stall;
  assign bus.fwd_a_sel   = r_a_sel;
  assign bus.fwd_b_sel   = r_b_sel;
  assign bus.ex_valid    = r_ex_valid;
  assign bus.stall_count = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - scoreboard bench for forwarding selects and load-use stall
module tb_fwd_hazard_ctrl;

  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [4:0] exp_q[$];

  fwd_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                       input logic urt, input logic rw, input int wr, input logic ld,
                       input logic fl);
    bus.id_valid      = v;
    bus.id_rs         = 5'(rs);
    bus.id_rt         = 5'(rt);
    bus.id_uses_rs    = urs;
    bus.id_uses_rt    = urt;
    bus.id_reg_write  = rw;
    bus.id_wr_reg     = 5'(wr);
    bus.id_mem_to_reg = ld;
    bus.flush         = fl;
  endtask

  task automatic cyc(input string tag, input logic v, input int rs, input int rt,
                     input logic urs, input logic urt, input logic rw, input int wr,
                     input logic ld, input logic fl, input logic e_stall,
                     input logic e_exv, input logic [1:0] e_a, input logic [1:0] e_b);
    logic [4:0] e;
    @(negedge clk);
    drive(v, rs, rt, urs, urt, rw, wr, ld, fl);
    #1;
    check({tag, ".stall"}, bus.stall, e_stall);
    exp_q.push_back({e_exv, e_a, e_b});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".q_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".ex_valid"}, bus.ex_valid, e[4]);
      check({tag, ".fwd_a"}, bus.fwd_a_sel, e[3:2]);
      check({tag, ".fwd_b"}, bus.fwd_b_sel, e[1:0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc("rst_ld",  1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("rst_use", 1, 2, 2, 1, 1, 1, 8, 0, 0, 0, 0, 2'd0, 2'd0);
    check("rst_cnt", bus.stall_count, 0);
    rst_n = 1'b1;

    // Reset arriving while a load-use stall is pending
    cyc("ms_ld", 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 2'd0, 2'd0);
    @(negedge clk);
    drive(1, 2, 2, 1, 1, 1, 8, 0, 0);
    #1;
    check("ms_stall_pre", bus.stall, 1);
    rst_n = 1'b0;
    #1;
    check("ms_stall_rst", bus.stall, 0);
    @(posedge clk);
    #1;
    check("ms_exv", bus.ex_valid, 0);
    check("ms_a", bus.fwd_a_sel, 0);
    check("ms_b", bus.fwd_b_sel, 0);
    check("ms_cnt", bus.stall_count, 0);
    rst_n = 1'b1;
    cyc("post_rst", 1, 2, 2, 1, 1, 1, 8, 0, 0, 0, 1, 2'd0, 2'd0);

    cyc("lu_ld",    1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 2'd0, 2'd0);
    cyc("lu_stall", 1, 2, 2, 1, 1, 1, 8, 0, 0, 1, 0, 2'd0, 2'd0);
    check("lu_cnt1", bus.stall_count, 1);
    cyc("lu_go",    1, 2, 2, 1, 1, 1, 8, 0, 0, 0, 1, 2'd2, 2'd2);
    check("lu_cnt2", bus.stall_count, 1);

    cyc("exm_p", 1, 1, 1, 1, 1, 1, 3, 0, 0, 0, 1, 2'd0, 2'd0);
    cyc("exm_c", 1, 3, 5, 1, 1, 1, 4, 0, 0, 0, 1, 2'd1, 2'd0);

    cyc("mwb_p",   1, 9, 10, 1, 1, 1, 3, 0, 0, 0, 1, 2'd0, 2'd0);
    cyc("mwb_nop", 0, 3, 3,  1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("mwb_c",   1, 7, 3,  1, 1, 1, 6, 0, 0, 0, 1, 2'd0, 2'd2);

    cyc("yng_p1", 1, 11, 12, 1, 1, 1, 3, 0, 0, 0, 1, 2'd0, 2'd0);
    cyc("yng_p2", 1, 13, 14, 1, 1, 1, 3, 0, 0, 0, 1, 2'd0, 2'd0);
    cyc("yng_c",  1, 3,  3,  1, 1, 1, 9, 0, 0, 0, 1, 2'd1, 2'd1);

    cyc("fl_ld",   1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 2'd0, 2'd0);
    cyc("fl_kill", 1, 2, 2, 1, 1, 1, 8, 0, 1, 0, 0, 2'd0, 2'd0);
    check("fl_cnt", bus.stall_count, 1);
    cyc("fl_next", 1, 2, 2, 1, 1, 1, 8, 0, 0, 0, 1, 2'd2, 2'd2);

    cyc("z_p",  1, 20, 21, 1, 1, 1, 0,  0, 0, 0, 1, 2'd0, 2'd0);
    cyc("z_c",  1, 0,  0,  1, 1, 1, 22, 0, 0, 0, 1, 2'd0, 2'd0);
    cyc("z_ld", 1, 0,  0,  0, 0, 1, 0,  1, 0, 0, 1, 2'd0, 2'd0);
    cyc("z_lu", 1, 0,  0,  1, 1, 1, 23, 0, 0, 0, 1, 2'd0, 2'd0);

    cyc("use_p", 1, 0, 0, 0, 0, 1, 5,  0, 0, 0, 1, 2'd0, 2'd0);
    cyc("use_c", 1, 5, 5, 0, 1, 1, 24, 0, 0, 0, 1, 2'd0, 2'd1);
    check("use_cnt", bus.stall_count, 1);

    for (int i = 0; i < 258; i++) begin
      cyc("sat_ld", 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 2'd0, 2'd0);
      cyc("sat_st", 1, 2, 2, 1, 1, 1, 8, 0, 0, 1, 0, 2'd0, 2'd0);
      if (i == 252) check("sat_254", bus.stall_count, 254);
      if (i == 253) check("sat_255", bus.stall_count, 255);
    end
    check("sat_hold", bus.stall_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Generates the select codes for the 3-input operand muxes at the EX-stage ALU inputs. It is the producer of the mux select codes that the operand muxes consume.
- Tracks destination registers of in-flight instructions in EX/MEM/WB. From these it registers forwarding selects for the instruction entering EX.
- Detects load-use hazards, drives the pipeline stall, and keeps a saturating stall counter for performance reporting.

Parameters:
REG_AW, 5, register-address width
CNT_W, 16, stall counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_rs  input  REG_AW  ID source register A
id_rt  input  REG_AW  ID source register B
id_uses_rs  input  1  instruction reads rs
id_uses_rt  input  1  instruction reads rt
id_reg_write  input  1  instruction writes a register
id_wr_reg  input  REG_AW  destination register, after the rd/rt select
id_mem_to_reg  input  1  instruction is a load
flush  input  1  kill the ID instruction this cycle (taken branch/jump)
stall  output  1  hold PC and IF/ID, insert bubble into EX (combinational)
fwd_a_sel  output  2  operand-A mux select for the instruction now in EX
fwd_b_sel  output  2  operand-B mux select for the instruction now in EX
ex_valid  output  1  EX holds a real (non-bubble) instruction
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Select encoding:
  - 2'b00 = register-file value
  - 2'b01 = EX/MEM ALU result
  - 2'b10 = MEM/WB write-back value
  - 2'b11 is never driven.
- Internal tracking: three stage entries E, M, W, each holding {v, rd, ld}. An entry is live when v=1, rd!=0 and the producer wrote a register; only live entries take part in matching.
- Load-use hazard: hz = id_valid & live(E) & E.ld & ((id_uses_rs & id_rs==E.rd) | (id_uses_rt & id_rt==E.rd)).
- Stall output: stall = hz & ~flush. flush has priority, because a killed instruction never needs its operands.
- Stage advance every clock edge, no global enable:
  - W <= M; M <= E.
  - E <= bubble (v=0) if ~id_valid | stall | flush.
  - Otherwise E <= {id_reg_write, id_wr_reg, id_mem_to_reg}, with v=id_reg_write.
- Registered selects (latency 1), computed at the same edge from the pre-edge E and M:
  - Source A: if id_uses_rs and live(E) and ~E.ld and E.rd==id_rs → 01.
  - Else if id_uses_rs and live(M) and M.rd==id_rs → 10.
  - Else → 00.
  - The EX/MEM match wins over MEM/WB (youngest producer first). Source B uses id_rt/id_uses_rt in the same way.
  - When E loads a bubble, both selects load 00.
- Register 0 is never forwarded.
- A producer already in the pre-edge W stage is served by the register-file write-through bypass; this block outputs 00 for it.
- ex_valid is registered: it is set when a real (non-bubble) instruction enters E, cleared for a bubble.
- stall_count increments by 1 on each edge where stall=1 and saturates at all-ones. It is never cleared except by reset.
- Reset (rst_n=0 at an edge), checked every cycle:
  - E, M and W are set invalid.
  - fwd_a_sel and fwd_b_sel = 00; ex_valid = 0; stall_count = 0.
  - While rst_n=0, stall is forced to 0.
  - Reset mid-stall: the hazard is dropped and the first instruction after reset proceeds without stall.
- Back-to-back stalls: a load followed by a dependent instruction stalls exactly 1 cycle. After the stall, the load is in M, so the dependent instruction gets select 10.

Decomposition:
- Shared pipeline package holds:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10
  - the stage-entry struct {v, rd, ld}
  - REG_AW
- One natural sub-module, fwd_match, is instantiated twice (A and B). It takes a source register, a use flag, E and M, and returns a select code.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 and a hazard pattern → stall=0, selects 00, ex_valid=0, stall_count=0.
- EX/MEM forward: add $3 then add $4,$3,$5 → the second instruction is in EX with fwd_a_sel=01, fwd_b_sel=00.
- MEM/WB forward: add $3, nop, sub $6,$7,$3 → fwd_b_sel=10. Two producers both writing $3, then a consumer → 01, youngest wins.
- Load-use: lw $2 then add $8,$2,$2 → stall=1 for exactly one cycle, EX gets a bubble (ex_valid=0, selects 00), then the add enters EX with both selects 10; stall_count=1.
- Flush priority: the same load-use pattern with flush=1 in the hazard cycle → stall=0, bubble in E, stall_count unchanged.
- $0 and saturation: add $0 then use $0 → selects 00. Force 2^CNT_W+3 stall cycles → stall_count holds 16'hFFFF.
